// File: rtl/mem_addr_counter.sv
// mem_addr_counter: parametrised up/down address counter for the memory driver.
// Runtime step size, synchronous load, and wrap / saturate / one-shot terminal
// handling. All outputs come from flops that update on the edge which samples
// enable/load.
module mem_addr_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             ovf,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    // Terminal count and modulus in WIDTH+1 bits so sums never overflow.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MAX_COUNT + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   out_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   ld_ext;
    logic             up_cross;
    logic             down_cross;
    logic             crossing;
    logic             wrap_mode;
    logic             oneshot_mode;
    logic [WIDTH-1:0] adv_val;
    logic [WIDTH-1:0] ld_val;
    logic             at_terminal;

    // Advance arithmetic: clamp step, detect crossing, pick the landing value.
    always_comb begin
        step_ext     = {1'b0, step};
        s_ext        = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
        out_ext      = {1'b0, out_q};
        sum_ext      = out_ext + s_ext;
        ld_ext       = {1'b0, load_val};
        up_cross     = (sum_ext > MAX_EXT);
        down_cross   = (s_ext > out_ext);
        // Mode 11 is an unused encoding and behaves as wrap.
        wrap_mode    = (mode != MODE_SAT) && (mode != MODE_ONESHOT);
        oneshot_mode = (mode == MODE_ONESHOT);
        crossing     = dir ? down_cross : up_cross;
        adv_val      = out_q;
        if (!dir) begin
            if (!up_cross) begin
                adv_val = WIDTH'(sum_ext);
            end else if (wrap_mode) begin
                adv_val = WIDTH'(sum_ext - MOD_EXT);
            end else begin
                adv_val = WIDTH'(MAX_EXT);
            end
        end else begin
            if (!down_cross) begin
                adv_val = WIDTH'(out_ext - s_ext);
            end else if (wrap_mode) begin
                adv_val = WIDTH'(out_ext + MOD_EXT - s_ext);
            end else begin
                adv_val = '0;
            end
        end
        at_terminal = dir ? (adv_val == '0) : (adv_val == WIDTH'(MAX_EXT));
        ld_val      = (ld_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : load_val;
    end

    // Next-state and next-output logic; load overrides everything but reset.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        done_d  = done_q;
        if (load) begin
            out_d   = ld_val;
            done_d  = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_DONE: begin
                    // Parked at the one-shot terminal until reloaded.
                    done_d = 1'b1;
                end
                default: begin
                    if (enable) begin
                        out_d   = adv_val;
                        valid_d = 1'b1;
                        ovf_d   = crossing;
                        if (oneshot_mode && at_terminal) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // State and output registers; reset clears without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign done  = done_q;
    assign busy  = (state_q == ST_RUN);

endmodule
